gmii_rx_frame_filter: RTL and testbench
=======================================

GMII_RX_FRAME_FILTER -- requirements
Module: gmii_rx_frame_filter

Interface
REQ-001 SHALL have parameter MAX_FRAME, default 1518, max frame bytes (dest MAC through FCS) held in the buffer.
REQ-002 SHALL have parameter MIN_FRAME, default 64, min accepted frame bytes including FCS.
REQ-003 SHALL have parameter MAC_ADDR, 48 bits, default 48'h02_00_00_00_00_01, station address.
REQ-004 SHALL have parameter PROMISCUOUS, default 0; 1 disables the address filter.
REQ-005 SHALL have one clock and async active-high reset: clock (input, 1, GMII rx clock, all logic on rising edge); reset (input, 1, asynchronous, active-high).
REQ-006 SHALL have GMII inputs: rx_data (input, 8, GMII byte), rx_dv (input, 1, data valid), rx_er (input, 1, receive error).
REQ-007 SHALL have stream outputs: out_data (output, 8, frame byte), out_valid (output, 1), out_last (output, 1, last byte), out_ready (input, 1, consumer accept).
REQ-008 SHALL have frame_len (output, clog2(MAX_FRAME+1), bytes of current frame excluding FCS, valid while out_valid).
REQ-009 SHALL have frames_ok, frames_crc_err, frames_dropped (output, 16 each, saturating counters).

Function
REQ-010 States: IDLE, PREAMBLE, DATA, DISCARD, CHECK, OUTPUT.
REQ-011 IDLE->PREAMBLE when rx_dv=1 and rx_data=8'h55; rx_dv=1 with any other byte -> DISCARD.
REQ-012 PREAMBLE: 8'h55 stays; 8'hD5 -> DATA; other byte, rx_er=1, or rx_dv=0 -> DISCARD (rx_dv=0 returns to IDLE next cycle without count).
REQ-013 DATA: each rx_dv=1 byte written to buffer at write index, index incremented, CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) updated over every byte including FCS.
REQ-014 DATA: rx_er=1 or write index reaching MAX_FRAME with rx_dv still 1 -> DISCARD, frames_dropped+1.
REQ-015 DATA->CHECK on first cycle with rx_dv=0.
REQ-016 CHECK (one cycle): CRC register equals residue 32'hC704DD7B and length >= MIN_FRAME -> filter check; else frames_crc_err+1 (CRC) or frames_dropped+1 (short), ->IDLE.
REQ-017 Filter passes if PROMISCUOUS=1, bytes 0..5 equal MAC_ADDR (byte 0 = MAC_ADDR[47:40]), or bytes 0..5 all 8'hFF; pass -> OUTPUT, frames_ok+1; fail -> IDLE, frames_dropped+1.
REQ-018 DISCARD: ignore input until rx_dv=0, then IDLE.
REQ-019 OUTPUT: out_valid=1; bytes 0..frame_len-1 presented in order (FCS never output); byte advances only on out_valid&out_ready; out_last=1 on byte frame_len-1; after that handshake -> IDLE.
REQ-020 out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Frame arriving while in OUTPUT (rx_dv=1): ignored until rx_dv=0, frames_dropped+1 once per such frame; buffered frame unaffected.
REQ-022 Read latency: first byte valid 1 cycle after entering OUTPUT; subsequent bytes 1 per cycle with out_ready held 1.
REQ-023 Counters saturate at 16'hFFFF, never wrap.
REQ-024 rx_dv falling mid-preamble or with zero DATA bytes SHALL not count as any frame.

Reset
REQ-025 reset=1 SHALL asynchronously force IDLE, out_valid=0, out_last=0, out_data=0, frame_len=0, all counters 0, indices 0, CRC to 0xFFFFFFFF.
REQ-026 Reset mid-DATA or mid-OUTPUT SHALL abandon the frame without counting; after release, next frame requires fresh preamble.

Verification
REQ-027 7x55, D5, 60-byte frame to MAC_ADDR + correct FCS, out_ready=1 -> 60 bytes out in order, out_last on byte 60, frame_len=60, frames_ok=1.
REQ-028 Same frame, one payload bit flipped -> no out_valid, frames_crc_err=1.
REQ-029 Dest 02:00:00:00:00:02, PROMISCUOUS=0, valid FCS -> frames_dropped=1; broadcast dest -> frames_ok=1; PROMISCUOUS=1 -> non-matching dest accepted.
REQ-030 Good frame, out_ready toggled 1/0 each cycle, second frame sent during OUTPUT -> first frame intact, stalled bytes stable, frames_dropped=1.
REQ-031 rx_er=1 on byte 20; separately 1600-byte frame with MAX_FRAME=1518 -> both DISCARD, frames_dropped=2, no output.
REQ-032 Assert reset on byte 30 of OUTPUT -> out_valid=0 immediately, counters 0; subsequent good frame accepted normally.

Source files
------------

// File: rtl/gmii_rx_frame_filter.sv
// gmii_rx_frame_filter
// Receives GMII frames, strips preamble/SFD, buffers the frame, checks the
// Ethernet FCS, minimum length and destination address, and replays accepted
// frames (without FCS) on a ready/valid byte stream.
//
// Ports:
//   clock, reset      GMII receive clock; asynchronous active-high reset
//   rx_data/dv/er     GMII receive byte, data valid, receive error
//   out_data/valid/   accepted frame bytes, handshake with out_ready,
//   out_last          out_last marks the final byte
//   frame_len         byte count of the presented frame excluding FCS
//   frames_ok,        saturating counters: accepted, FCS errors, and
//   frames_crc_err,   frames dropped for error/size/address/busy reasons
//   frames_dropped
module gmii_rx_frame_filter #(
   parameter int          MAX_FRAME   = 1518,
   parameter int          MIN_FRAME   = 64,
   parameter logic [47:0] MAC_ADDR    = 48'h02_00_00_00_00_01,
   parameter bit          PROMISCUOUS = 1'b0,
   localparam int         LW          = $clog2(MAX_FRAME + 1),
   localparam int         AW          = $clog2(MAX_FRAME)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [7:0]    rx_data,
   input  logic          rx_dv,
   input  logic          rx_er,
   output logic [7:0]    out_data,
   output logic          out_valid,
   output logic          out_last,
   input  logic          out_ready,
   output logic [LW-1:0] frame_len,
   output logic [15:0]   frames_ok,
   output logic [15:0]   frames_crc_err,
   output logic [15:0]   frames_dropped
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_PREAMBLE, ST_DATA, ST_DISCARD, ST_CHECK, ST_OUTPUT
   } state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] wr_idx_q, wr_idx_d;
   logic [LW-1:0] rd_idx_q, rd_idx_d;
   logic [31:0]   crc_q, crc_d;
   logic [47:0]   dest_q, dest_d;
   logic [7:0]    out_data_q, out_data_d;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
   logic [LW-1:0] frame_len_q, frame_len_d;
   logic [15:0]   ok_q, ok_d, crc_err_q, crc_err_d, drop_q, drop_d;
   logic          rx_busy_q, rx_busy_d;
   logic          mem_we;
   logic          crc_ok, len_ok, addr_ok;
   logic [7:0]    buf_mem [MAX_FRAME];

   // Byte-wise update of the reflected CRC-32 register (no final inversion).
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // The reflected register holds the residue bit-reversed, so reverse it
   // before comparing with the conventional residue constant.
   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++)
         r[i] = v[31-i];
      return r;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign crc_ok  = (bitrev32(crc_q) == 32'hC704DD7B);
   assign len_ok  = (wr_idx_q >= LW'(MIN_FRAME));
   assign addr_ok = PROMISCUOUS || (dest_q == MAC_ADDR) || (dest_q == 48'hFFFF_FFFF_FFFF);

   // Next-state logic. The destination address is captured by shifting the
   // first six bytes into dest_q so the filter never needs a multi-port read
   // of the buffer. While OUTPUT is replaying, a newly arriving frame is
   // counted once on its first byte and tracked by rx_busy so that, if it is
   // still running when replay finishes, the rest of it is discarded.
   always_comb begin
      state_d     = state_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      crc_d       = crc_q;
      dest_d      = dest_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      frame_len_d = frame_len_q;
      ok_d        = ok_q;
      crc_err_d   = crc_err_q;
      drop_d      = drop_q;
      rx_busy_d   = rx_busy_q;
      mem_we      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            wr_idx_d = '0;
            crc_d    = 32'hFFFF_FFFF;
            if (rx_dv)
               state_d = (rx_data == 8'h55) ? ST_PREAMBLE : ST_DISCARD;
         end
         ST_PREAMBLE: begin
            if (!rx_dv || rx_er)
               state_d = ST_DISCARD;
            else if (rx_data == 8'hD5)
               state_d = ST_DATA;
            else if (rx_data != 8'h55)
               state_d = ST_DISCARD;
         end
         ST_DATA: begin
            if (rx_dv) begin
               if (rx_er || wr_idx_q == LW'(MAX_FRAME)) begin
                  state_d = ST_DISCARD;
                  drop_d  = sat_inc(drop_q);
               end else begin
                  mem_we   = 1'b1;
                  wr_idx_d = wr_idx_q + LW'(1);
                  crc_d    = crc_byte(crc_q, rx_data);
                  if (wr_idx_q < LW'(6))
                     dest_d = {dest_q[39:0], rx_data};
               end
            end else begin
               state_d = (wr_idx_q == '0) ? ST_IDLE : ST_CHECK;
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
            if (!crc_ok)
               crc_err_d = sat_inc(crc_err_q);
            else if (!len_ok || !addr_ok)
               drop_d = sat_inc(drop_q);
            else begin
               state_d     = ST_OUTPUT;
               ok_d        = sat_inc(ok_q);
               frame_len_d = wr_idx_q - LW'(4);
               rd_idx_d    = '0;
               rx_busy_d   = 1'b0;
            end
         end
         ST_DISCARD: begin
            if (!rx_dv)
               state_d = ST_IDLE;
         end
         ST_OUTPUT: begin
            if (rx_dv && !rx_busy_q) begin
               rx_busy_d = 1'b1;
               drop_d    = sat_inc(drop_q);
            end else if (!rx_dv) begin
               rx_busy_d = 1'b0;
            end
            if (out_valid_q && out_ready && out_last_q) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               state_d     = rx_dv ? ST_DISCARD : ST_IDLE;
            end else if (!out_valid_q || out_ready) begin
               out_data_d  = buf_mem[rd_idx_q[AW-1:0]];
               out_last_d  = (rd_idx_q == frame_len_q - LW'(1));
               out_valid_d = 1'b1;
               rd_idx_d    = rd_idx_q + LW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and status registers; reset abandons any frame in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         crc_q       <= 32'hFFFF_FFFF;
         dest_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         frame_len_q <= '0;
         ok_q        <= '0;
         crc_err_q   <= '0;
         drop_q      <= '0;
         rx_busy_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         crc_q       <= crc_d;
         dest_q      <= dest_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         frame_len_q <= frame_len_d;
         ok_q        <= ok_d;
         crc_err_q   <= crc_err_d;
         drop_q      <= drop_d;
         rx_busy_q   <= rx_busy_d;
      end
   end

   // Frame buffer has no reset; stale contents are never read because the
   // read side only walks indices written by the frame being replayed.
   always_ff @(posedge clock) begin
      if (mem_we)
         buf_mem[wr_idx_q[AW-1:0]] <= rx_data;
   end

   assign out_data       = out_data_q;
   assign out_valid      = out_valid_q;
   assign out_last       = out_last_q;
   assign frame_len      = frame_len_q;
   assign frames_ok      = ok_q;
   assign frames_crc_err = crc_err_q;
   assign frames_dropped = drop_q;

endmodule

// File: tb/tb_gmii_rx_frame_filter.sv
// Testbench for gmii_rx_frame_filter: table of single-frame scenarios plus
// hand-written sequences for stalls, overlapping frames, aborted preambles
// and reset during replay. A second instance runs in promiscuous mode.
module tb_gmii_rx_frame_filter;

   localparam int          LW  = $clog2(1518 + 1);
   localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;

   logic          clock = 1'b0;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_dv, rx_er, out_ready;
   logic [7:0]    out_data, p_out_data;
   logic          out_valid, out_last, p_out_valid, p_out_last;
   logic [LW-1:0] frame_len, p_frame_len;
   logic [15:0]   frames_ok, frames_crc_err, frames_dropped;
   logic [15:0]   p_frames_ok, p_frames_crc_err, p_frames_dropped;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [47:0] dest;
      int          len;
      bit          flip;
      int          err_at;
      int          e_ok;
      int          e_crc;
      int          e_drop;
      int          e_pok;
      bit          e_out;
   } vec_t;

   vec_t       tbl [9];
   logic [7:0] frame_q [$];
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   int         last_pos;
   int         got_len;
   bit         got_last;
   int         stall_err;
   bit         prev_stall;
   logic [7:0] prev_data;
   logic       prev_last;

   gmii_rx_frame_filter dut (
      .clock(clock), .reset(reset), .rx_data(rx_data), .rx_dv(rx_dv), .rx_er(rx_er),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .frame_len(frame_len), .frames_ok(frames_ok), .frames_crc_err(frames_crc_err),
      .frames_dropped(frames_dropped)
   );

   gmii_rx_frame_filter #(.PROMISCUOUS(1'b1)) dut_p (
      .clock(clock), .reset(reset), .rx_data(rx_data), .rx_dv(rx_dv), .rx_er(rx_er),
      .out_data(p_out_data), .out_valid(p_out_valid), .out_last(p_out_last), .out_ready(1'b1),
      .frame_len(p_frame_len), .frames_ok(p_frames_ok), .frames_crc_err(p_frames_crc_err),
      .frames_dropped(p_frames_dropped)
   );

   always #5 clock = ~clock;

   // Output monitor: samples on the falling edge, logging bytes that will be
   // accepted at the next rising edge and verifying stalled bytes hold.
   initial begin
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && (!out_valid || out_data != prev_data || out_last != prev_last))
               stall_err++;
            if (out_valid && out_ready) begin
               if (got_q.size() == 0)
                  got_len = int'(frame_len);
               if (out_last) begin
                  last_pos = got_q.size();
                  got_last = 1'b1;
               end
               got_q.push_back(out_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
         end
      end
   end

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      got_q.delete();
      last_pos   = -1;
      got_len    = -1;
      got_last   = 1'b0;
      stall_err  = 0;
      prev_stall = 1'b0;
   endtask

   task automatic drive(input logic [7:0] d, input logic dv, input logic er);
      @(posedge clock);
      #1;
      rx_data = d;
      rx_dv   = dv;
      rx_er   = er;
   endtask

   task automatic do_reset();
      @(posedge clock);
      #1;
      reset = 1'b1;
      rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      clear_mon();
   endtask

   // Builds dest/src/type/payload of len bytes into frame_q and appends the
   // FCS, computed here with a bit-serial LSB-first CRC-32.
   task automatic build_frame(input logic [47:0] dest, input int len, input int seed);
      logic [31:0] c;
      logic [7:0]  b;
      logic        fb;
      frame_q.delete();
      for (int i = 0; i < len; i++) begin
         if (i < 6)       b = dest[47 - 8*i -: 8];
         else if (i < 11) b = 8'h00;
         else if (i == 11) b = 8'hAA;
         else if (i == 12) b = 8'h08;
         else if (i == 13) b = 8'h00;
         else             b = 8'(i * 7 + seed);
         frame_q.push_back(b);
      end
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < len; i++)
         for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ frame_q[i][k];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
         end
      c = ~c;
      for (int k = 0; k < 4; k++)
         frame_q.push_back(c[8*k +: 8]);
   endtask

   task automatic applyStimulus(input int err_at);
      for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
      drive(8'hD5, 1'b1, 1'b0);
      for (int i = 0; i < frame_q.size(); i++)
         drive(frame_q[i], 1'b1, (i == err_at));
      drive(8'h00, 1'b0, 1'b0);
   endtask

   task automatic wait_out(input int budget);
      for (int c = 0; c < budget && !got_last; c++) @(posedge clock);
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic check_data(input string name, input int len);
      int mism;
      mism = 0;
      for (int i = 0; i < len && i < got_q.size(); i++)
         if (got_q[i] !== exp_q[i]) mism++;
      checkOutput({name, " count"}, got_q.size(), len);
      checkOutput({name, " data_mismatches"}, mism, 0);
      checkOutput({name, " last_pos"}, last_pos, len - 1);
      checkOutput({name, " frame_len"}, got_len, len);
   endtask

   initial begin
      reset = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00; out_ready = 1'b1;
      clear_mon();
      #12;
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset out_last", out_last, 0);
      checkOutput("reset out_data", out_data, 0);
      checkOutput("reset frame_len", frame_len, 0);
      checkOutput("reset counters", {frames_ok, frames_crc_err, frames_dropped}, 0);

      tbl[0] = '{MAC,             60,   1'b0, -1, 1, 0, 0, 1, 1'b1};
      tbl[1] = '{MAC,             60,   1'b1, -1, 0, 1, 0, 0, 1'b0};
      tbl[2] = '{48'h020000000002, 60,  1'b0, -1, 0, 0, 1, 1, 1'b0};
      tbl[3] = '{48'hFFFFFFFFFFFF, 60,  1'b0, -1, 1, 0, 0, 1, 1'b1};
      tbl[4] = '{MAC,             60,   1'b0, 20, 0, 0, 1, 0, 1'b0};
      tbl[5] = '{MAC,             1596, 1'b0, -1, 0, 0, 1, 0, 1'b0};
      tbl[6] = '{MAC,             59,   1'b0, -1, 0, 0, 1, 0, 1'b0};
      tbl[7] = '{MAC,             1514, 1'b0, -1, 1, 0, 0, 1, 1'b1};
      tbl[8] = '{MAC,             1515, 1'b0, -1, 0, 0, 1, 0, 1'b0};

      for (int r = 0; r < 9; r++) begin
         string nm;
         nm = $sformatf("row%0d", r);
         do_reset();
         out_ready = 1'b1;
         build_frame(tbl[r].dest, tbl[r].len, r + 3);
         exp_q = frame_q;
         if (tbl[r].flip) frame_q[20] = frame_q[20] ^ 8'h04;
         applyStimulus(tbl[r].err_at);
         wait_out(tbl[r].e_out ? tbl[r].len + 40 : 30);
         checkOutput({nm, " frames_ok"}, frames_ok, tbl[r].e_ok);
         checkOutput({nm, " frames_crc_err"}, frames_crc_err, tbl[r].e_crc);
         checkOutput({nm, " frames_dropped"}, frames_dropped, tbl[r].e_drop);
         checkOutput({nm, " promisc frames_ok"}, p_frames_ok, tbl[r].e_pok);
         checkOutput({nm, " out_valid idle"}, out_valid, 0);
         if (tbl[r].e_out) check_data(nm, tbl[r].len);
         else checkOutput({nm, " no output"}, got_q.size(), 0);
      end

      // Stalled replay with a second frame arriving during OUTPUT.
      do_reset();
      out_ready = 1'b0;
      build_frame(MAC, 60, 11);
      exp_q = frame_q;
      fork
         begin
            applyStimulus(-1);
            for (int c = 0; c < 100 && !out_valid; c++) drive(8'h00, 1'b0, 1'b0);
            repeat (4) drive(8'h00, 1'b0, 1'b0);
            build_frame(48'hFFFFFFFFFFFF, 60, 5);
            applyStimulus(-1);
         end
         begin
            for (int c = 0; c < 400 && !got_last; c++) begin
               @(posedge clock);
               #1;
               out_ready = ~out_ready;
            end
         end
      join
      out_ready = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      check_data("stall", 60);
      checkOutput("stall stable_errors", stall_err, 0);
      checkOutput("stall frames_ok", frames_ok, 1);
      checkOutput("stall frames_dropped", frames_dropped, 1);

      // Aborted preamble and SFD with no data bytes count as nothing.
      do_reset();
      repeat (3) drive(8'h55, 1'b1, 1'b0);
      repeat (5) drive(8'h00, 1'b0, 1'b0);
      repeat (7) drive(8'h55, 1'b1, 1'b0);
      drive(8'hD5, 1'b1, 1'b0);
      repeat (6) drive(8'h00, 1'b0, 1'b0);
      checkOutput("abort counters", {frames_ok, frames_crc_err, frames_dropped}, 0);
      checkOutput("abort no output", got_q.size(), 0);

      // Reset during replay, then a fresh good frame.
      do_reset();
      build_frame(MAC, 60, 9);
      exp_q = frame_q;
      applyStimulus(-1);
      for (int c = 0; c < 200 && got_q.size() < 30; c++) @(posedge clock);
      #1;
      checkOutput("midreset frames_ok before", frames_ok, 1);
      reset = 1'b1;
      #1;
      checkOutput("midreset out_valid", out_valid, 0);
      checkOutput("midreset counters", {frames_ok, frames_crc_err, frames_dropped}, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      clear_mon();
      applyStimulus(-1);
      wait_out(100);
      check_data("after_reset", 60);
      checkOutput("after_reset frames_ok", frames_ok, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
